// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master SRAM front end.
package mem_arbiter_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Port identifiers
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Bit positions in err
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_TMO = 1;

  // Choose the port to grant among pending slots.
  // rr_ptr names the port preferred on contention when round-robin is enabled.
  function automatic logic pick_port(input logic rr_en, input logic pend_i,
                                     input logic pend_d, input logic rr_ptr);
    if (pend_i && pend_d) return rr_en ? rr_ptr : PORT_D;
    return pend_d ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Simple strobe/ack memory bus: master issues stb with fields, slave answers ack+dtr.
interface mem_arbiter_if;
  logic        stb;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic        ack;
  logic [31:0] dtr;

  modport master (output stb, output rw, output addr, output dtw,
                  input  ack, input  dtr);
  modport slave  (input  stb, input  rw, input  addr, input  dtw,
                  output ack, output dtr);
endinterface

// File: rtl/mem_arbiter_slot.sv
// One-entry request register with pending bit and sticky overflow flag.
module arb_req_slot #(
  parameter bit READ_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] dtw,
  input  logic        clr,
  output logic        pending,
  output logic        q_rw,
  output logic [31:0] q_addr,
  output logic [31:0] q_dtw,
  output logic        ovf
);

  // Latch a request into an empty slot; flag requests arriving while full
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      q_rw    <= 1'b0;
      q_addr  <= '0;
      q_dtw   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (clr) pending <= 1'b0;
      if (stb && !pending) begin
        pending <= 1'b1;
        q_rw    <= READ_ONLY ? 1'b0 : rw;
        q_addr  <= addr;
        q_dtw   <= READ_ONLY ? '0 : dtw;
      end
      if (stb && pending) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the SRAM controller; one transaction in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_ARB      = 1,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_if.slave         i_bus,
  mem_arbiter_if.slave         d_bus,
  mem_arbiter_if.master        m_bus,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam int unsigned CW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  logic        pend_i, pend_d, ovf_i, ovf_d;
  logic        rw_i, rw_d;
  logic [31:0] addr_i, addr_d, dtw_i, dtw_d;
  logic [0:0]  state;
  logic        owner, rr_ptr, winner, tmo;
  logic        done, clr_i, clr_d;
  logic [CW-1:0] cnt, cnt_inc;

  arb_req_slot #(.READ_ONLY(1'b1)) u_slot_i (
    .clk(clk), .reset(reset), .stb(i_bus.stb), .rw(i_bus.rw), .addr(i_bus.addr),
    .dtw(i_bus.dtw), .clr(clr_i), .pending(pend_i), .q_rw(rw_i), .q_addr(addr_i),
    .q_dtw(dtw_i), .ovf(ovf_i)
  );

  arb_req_slot #(.READ_ONLY(1'b0)) u_slot_d (
    .clk(clk), .reset(reset), .stb(d_bus.stb), .rw(d_bus.rw), .addr(d_bus.addr),
    .dtw(d_bus.dtw), .clr(clr_d), .pending(pend_d), .q_rw(rw_d), .q_addr(addr_d),
    .q_dtw(dtw_d), .ovf(ovf_d)
  );

  assign done    = (state == ST_WAIT) && m_bus.ack;
  assign clr_i   = done && (owner == PORT_I);
  assign clr_d   = done && (owner == PORT_D);
  assign winner  = pick_port(RR_ARB != 0, pend_i, pend_d, rr_ptr);
  assign cnt_inc = cnt + CW'(1);
  assign busy    = pend_i | pend_d | (state != ST_IDLE);
  assign err     = {tmo, ovf_i | ovf_d};

  // Grant, downstream strobe, completion routing and timeout tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= PORT_I;
      rr_ptr      <= PORT_I;
      cnt         <= '0;
      tmo         <= 1'b0;
      m_bus.stb   <= 1'b0;
      m_bus.rw    <= 1'b0;
      m_bus.addr  <= '0;
      m_bus.dtw   <= '0;
      i_bus.ack   <= 1'b0;
      i_bus.dtr   <= '0;
      d_bus.ack   <= 1'b0;
      d_bus.dtr   <= '0;
    end else begin
      i_bus.ack <= 1'b0;
      d_bus.ack <= 1'b0;
      m_bus.stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_i || pend_d) begin
            m_bus.stb  <= 1'b1;
            m_bus.rw   <= (winner == PORT_D) ? rw_d   : rw_i;
            m_bus.addr <= (winner == PORT_D) ? addr_d : addr_i;
            m_bus.dtw  <= (winner == PORT_D) ? dtw_d  : dtw_i;
            owner      <= winner;
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
        default: begin
          if (m_bus.ack) begin
            if (owner == PORT_D) begin
              d_bus.ack <= 1'b1;
              d_bus.dtr <= m_bus.dtr;
            end else begin
              i_bus.ack <= 1'b1;
              i_bus.dtr <= m_bus.dtr;
            end
            rr_ptr <= ~owner;
            state  <= ST_IDLE;
          end else if (cnt != TMO) begin
            cnt <= cnt_inc;
            if ((TIMEOUT_CYC != 0) && (cnt_inc == TMO)) tmo <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
